// File: rtl/shake_ctrl_pkg.sv
// Shared definitions for the SHAKE sponge controller: FSM states, rate sizes
// and the mode encoding.
package shake_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PERMUTE,
    ST_SQUEEZE
  } state_e;

  localparam int RATE128_WORDS = 21;
  localparam int RATE256_WORDS = 17;

  localparam logic MODE_SHAKE128 = 1'b0;
  localparam logic MODE_SHAKE256 = 1'b1;

  // Highest lane index inside one rate block for the selected mode.
  function automatic logic [4:0] rate_max(input logic mode);
    return (mode == MODE_SHAKE256) ? 5'(RATE256_WORDS - 1) : 5'(RATE128_WORDS - 1);
  endfunction

endpackage

// File: rtl/shake_ctrl_modcnt.sv
// Modulo counter with runtime maximum: wraps to zero after max, clear wins
// over enable, last flags the terminal count.
module shake_modcnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] max,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last = (cnt_q == max);
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = last ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shake_ctrl.sv
// SHAKE128/256 sponge sequencer driving an external Keccak state datapath.
// Define SHAKE_CTRL_PERF_EN to add the perm_count permutation counter output.
module shake_ctrl
  import shake_ctrl_pkg::*;
#(
  parameter int ROUNDS    = 24,
  parameter int OUT_LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  input  logic [OUT_LEN_W-1:0] out_len,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 state_clr,
  output logic                 absorb_en,
  output logic [4:0]           word_idx,
  output logic                 round_en,
  output logic [4:0]           round_idx,
  output logic                 busy,
  output logic                 done
`ifdef SHAKE_CTRL_PERF_EN
  , output logic [31:0]        perm_count
`endif
);

  state_e               state_q;
  logic                 mode_q;
  logic [OUT_LEN_W-1:0] rem_q;
  logic                 absorbed_q;
  logic                 done_q;

  logic in_hs;
  logic out_hs;
  logic word_last;
  logic word_clr;
  logic round_last;

  assign in_ready  = (state_q == ST_ABSORB);
  assign out_valid = (state_q == ST_SQUEEZE);
  assign round_en  = (state_q == ST_PERMUTE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign state_clr = (state_q == ST_IDLE) && start;

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign absorb_en = in_hs;

  // Early in_last or the final squeeze word returns the lane index to zero
  // even when the block is not full.
  assign word_clr = (in_hs && in_last) || (out_hs && (rem_q == OUT_LEN_W'(1)));

  shake_modcnt #(.W(5)) u_word_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (in_hs || out_hs),
    .clr  (word_clr),
    .max  (rate_max(mode_q)),
    .cnt  (word_idx),
    .last (word_last)
  );

  shake_modcnt #(.W(5)) u_round_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (round_en),
    .clr  (!round_en),
    .max  (5'(ROUNDS - 1)),
    .cnt  (round_idx),
    .last (round_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_SHAKE128;
      rem_q      <= '0;
      absorbed_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mode_q     <= mode;
            rem_q      <= out_len;
            absorbed_q <= 1'b0;
            state_q    <= ST_ABSORB;
          end
        end
        ST_ABSORB: begin
          if (in_hs) begin
            if (in_last) absorbed_q <= 1'b1;
            if (in_last || word_last) state_q <= ST_PERMUTE;
          end
        end
        ST_PERMUTE: begin
          if (round_last) begin
            if (!absorbed_q) begin
              state_q <= ST_ABSORB;
            end else if (rem_q != '0) begin
              state_q <= ST_SQUEEZE;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        ST_SQUEEZE: begin
          if (out_ready) begin
            if (rem_q != '0) rem_q <= rem_q - OUT_LEN_W'(1);
            if (rem_q == OUT_LEN_W'(1)) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else if (word_last) begin
              state_q <= ST_PERMUTE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef SHAKE_CTRL_PERF_EN
  logic [31:0] perm_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perm_cnt_q <= '0;
    end else if (round_en && round_last) begin
      perm_cnt_q <= perm_cnt_q + 32'd1;
    end
  end

  assign perm_count = perm_cnt_q;
`endif

endmodule
